// File: rtl/antares_pipe_skid_register_pkg.sv
// Shared constants for the antares pipeline register: handshake state
// encoding {skid_v, main_v} and default widths.
package antares_pipe_skid_register_pkg;

  typedef enum logic [1:0] {
    ANTARES_PIPE_EMPTY = 2'b00,
    ANTARES_PIPE_FULL  = 2'b01,
    ANTARES_PIPE_SKID  = 2'b11
  } pipe_state_e;

  localparam int ANTARES_PIPE_DATA_WIDTH = 72;
  localparam int ANTARES_PIPE_CTRL_WIDTH = 1;
  localparam int ANTARES_PIPE_CNT_WIDTH  = 16;

endpackage

// File: rtl/antares_pipe_entry.sv
// One pipeline entry: valid flag, data and side-effect ctrl with load/drop/clear.
// Clear and drop zero ctrl; data is left stale since it has no side effects.
module antares_pipe_entry
  import antares_pipe_skid_register_pkg::*;
#(
  parameter int DATA_WIDTH = ANTARES_PIPE_DATA_WIDTH,
  parameter int CTRL_WIDTH = ANTARES_PIPE_CTRL_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  drop,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic [CTRL_WIDTH-1:0] load_ctrl,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic [CTRL_WIDTH-1:0] ctrl
);

  // Entry storage; clear (flush) has priority over load and drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= {DATA_WIDTH{1'b0}};
      ctrl  <= {CTRL_WIDTH{1'b0}};
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= {CTRL_WIDTH{1'b0}};
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      ctrl  <= load_ctrl;
    end else if (drop) begin
      valid <= 1'b0;
      ctrl  <= {CTRL_WIDTH{1'b0}};
    end else begin
      valid <= valid;
    end
  end

endmodule

// File: rtl/antares_pipe_skid_register.sv
// Parametrised pipeline register with valid/ready handshake, optional
// 2-entry skid buffer (registered in_ready), ctrl squashing and stall counter.
module antares_pipe_skid_register
  import antares_pipe_skid_register_pkg::*;
#(
  parameter int DATA_WIDTH = ANTARES_PIPE_DATA_WIDTH,
  parameter int CTRL_WIDTH = ANTARES_PIPE_CTRL_WIDTH,
  parameter int SKID_EN    = 1,
  parameter int CNT_WIDTH  = ANTARES_PIPE_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic                  main_v_s;
  logic [DATA_WIDTH-1:0] main_data_s;
  logic [CTRL_WIDTH-1:0] main_ctrl_s;
  logic                  skid_v_s;
  logic [DATA_WIDTH-1:0] skid_data_s;
  logic [CTRL_WIDTH-1:0] skid_ctrl_s;

  logic                  in_xfer_s;
  logic                  out_xfer_s;
  logic                  main_load_s;
  logic                  main_drop_s;
  logic                  main_from_skid_s;
  logic                  skid_load_s;
  logic                  skid_drop_s;
  logic [DATA_WIDTH-1:0] main_ld_data_s;
  logic [CTRL_WIDTH-1:0] main_ld_ctrl_s;
  pipe_state_e           state_s;
  logic [CNT_WIDTH-1:0]  stall_cnt_r;

  assign in_xfer_s  = in_valid & in_ready;
  assign out_xfer_s = main_v_s & out_ready;

  // Entry load/drop decisions from the current {skid_v, main_v} state.
  always_comb begin
    main_load_s      = 1'b0;
    main_drop_s      = 1'b0;
    main_from_skid_s = 1'b0;
    skid_load_s      = 1'b0;
    skid_drop_s      = 1'b0;
    state_s          = pipe_state_e'({skid_v_s, main_v_s});
    case (state_s)
      ANTARES_PIPE_EMPTY: begin
        main_load_s = in_xfer_s;
      end
      ANTARES_PIPE_FULL: begin
        main_load_s = in_xfer_s & out_xfer_s;
        main_drop_s = out_xfer_s & ~in_xfer_s;
        skid_load_s = in_xfer_s & ~out_xfer_s;
      end
      ANTARES_PIPE_SKID: begin
        main_load_s      = out_xfer_s;
        main_from_skid_s = 1'b1;
        skid_drop_s      = out_xfer_s;
      end
      default: begin
        main_load_s      = 1'b0;
        main_drop_s      = 1'b0;
        main_from_skid_s = 1'b0;
        skid_load_s      = 1'b0;
        skid_drop_s      = 1'b0;
      end
    endcase
  end

  // Main entry refills from skid when draining, otherwise from upstream.
  always_comb begin
    main_ld_data_s = in_data;
    main_ld_ctrl_s = in_ctrl;
    if (main_from_skid_s) begin
      main_ld_data_s = skid_data_s;
      main_ld_ctrl_s = skid_ctrl_s;
    end else begin
      main_ld_data_s = in_data;
      main_ld_ctrl_s = in_ctrl;
    end
  end

  antares_pipe_entry #(
    .DATA_WIDTH(DATA_WIDTH),
    .CTRL_WIDTH(CTRL_WIDTH)
  ) u_main (
    .clk      (clk),
    .rst      (rst),
    .load     (main_load_s),
    .drop     (main_drop_s),
    .clear    (flush),
    .load_data(main_ld_data_s),
    .load_ctrl(main_ld_ctrl_s),
    .valid    (main_v_s),
    .data     (main_data_s),
    .ctrl     (main_ctrl_s)
  );

  generate
    if (SKID_EN != 0) begin : gen_skid
      antares_pipe_entry #(
        .DATA_WIDTH(DATA_WIDTH),
        .CTRL_WIDTH(CTRL_WIDTH)
      ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .load     (skid_load_s),
        .drop     (skid_drop_s),
        .clear    (flush),
        .load_data(in_data),
        .load_ctrl(in_ctrl),
        .valid    (skid_v_s),
        .data     (skid_data_s),
        .ctrl     (skid_ctrl_s)
      );
      // Registered ready: no combinational path from out_ready.
      assign in_ready = ~skid_v_s;
    end else begin : gen_noskid
      assign skid_v_s    = 1'b0;
      assign skid_data_s = {DATA_WIDTH{1'b0}};
      assign skid_ctrl_s = {CTRL_WIDTH{1'b0}};
      assign in_ready    = out_ready | ~main_v_s;
    end
  endgenerate

  // Saturating backpressure counter; only rst clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= {CNT_WIDTH{1'b0}};
    end else if (main_v_s && !out_ready && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + CNT_ONE;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign out_valid = main_v_s;
  assign out_data  = main_data_s;
  assign out_ctrl  = main_ctrl_s & {CTRL_WIDTH{main_v_s}};
  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_antares_pipe_skid_register.sv
// Bench for antares_pipe_skid_register: three configurations (default, 4-bit
// counter, no skid) driven together and checked against a FIFO-level model.
module tb_antares_pipe_skid_register;

  localparam int DW = 72;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ctrl = 1'b0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;

  logic          rdy0, rdy1, rdy2;
  logic          ov0, ov1, ov2;
  logic [DW-1:0] od0, od1, od2;
  logic          oc0, oc1, oc2;
  logic [15:0]   sc0, sc2;
  logic [3:0]    sc1;

  antares_pipe_skid_register #(.DATA_WIDTH(DW), .CTRL_WIDTH(1), .SKID_EN(1), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
    .in_ctrl(in_ctrl), .flush(flush), .out_valid(ov0), .out_ready(out_ready),
    .out_data(od0), .out_ctrl(oc0), .stall_cnt(sc0));

  antares_pipe_skid_register #(.DATA_WIDTH(DW), .CTRL_WIDTH(1), .SKID_EN(1), .CNT_WIDTH(4)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
    .in_ctrl(in_ctrl), .flush(flush), .out_valid(ov1), .out_ready(out_ready),
    .out_data(od1), .out_ctrl(oc1), .stall_cnt(sc1));

  antares_pipe_skid_register #(.DATA_WIDTH(DW), .CTRL_WIDTH(1), .SKID_EN(0), .CNT_WIDTH(16)) u_noskid (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .in_data(in_data),
    .in_ctrl(in_ctrl), .flush(flush), .out_valid(ov2), .out_ready(out_ready),
    .out_data(od2), .out_ctrl(oc2), .stall_cnt(sc2));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: each DUT is a FIFO of capacity 2 (skid) or 1 (no skid).
  int          msize [3];
  logic [72:0] mem [3][2];
  int          mstall [3];
  int          stall_max [3] = '{65535, 15, 65535};
  bit          has_skid [3] = '{1'b1, 1'b1, 1'b0};

  function automatic logic model_ready(input int i, input logic ordy);
    if (has_skid[i]) return (msize[i] < 2);
    return (msize[i] == 0) || ordy;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      msize[i]  = 0;
      mstall[i] = 0;
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 3; i++) begin
      logic          g_rdy, g_ov, g_oc;
      logic [DW-1:0] g_od;
      logic [15:0]   g_sc;
      case (i)
        0: begin g_rdy = rdy0; g_ov = ov0; g_oc = oc0; g_od = od0; g_sc = sc0; end
        1: begin g_rdy = rdy1; g_ov = ov1; g_oc = oc1; g_od = od1; g_sc = {12'd0, sc1}; end
        default: begin g_rdy = rdy2; g_ov = ov2; g_oc = oc2; g_od = od2; g_sc = sc2; end
      endcase
      check_eq($sformatf("%s.in_ready[%0d]", tag, i), 128'(g_rdy), 128'(model_ready(i, out_ready)));
      check_eq($sformatf("%s.out_valid[%0d]", tag, i), 128'(g_ov), 128'(msize[i] > 0));
      check_eq($sformatf("%s.out_ctrl[%0d]", tag, i), 128'(g_oc),
               128'((msize[i] > 0) ? mem[i][0][72] : 1'b0));
      if (msize[i] > 0)
        check_eq($sformatf("%s.out_data[%0d]", tag, i), 128'(g_od), 128'(mem[i][0][71:0]));
      check_eq($sformatf("%s.stall_cnt[%0d]", tag, i), 128'(g_sc), 128'(mstall[i]));
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      logic rd, ox, ix;
      rd = model_ready(i, out_ready);
      ox = (msize[i] > 0) && out_ready;
      ix = in_valid && rd;
      if ((msize[i] > 0) && !out_ready && (mstall[i] < stall_max[i])) mstall[i]++;
      if (flush) begin
        msize[i] = 0;
      end else begin
        if (ox) begin
          mem[i][0] = mem[i][1];
          msize[i]--;
        end
        if (ix) begin
          mem[i][msize[i]] = {in_ctrl, in_data};
          msize[i]++;
        end
      end
    end
  endtask

  // Called at a negedge: drive, check settled outputs, advance model past the posedge.
  task automatic cycle(input string tag, input logic iv, input logic [DW-1:0] d,
                       input logic c, input logic fl, input logic ordy);
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    flush     = fl;
    out_ready = ordy;
    #1;
    check_all(tag);
    model_step();
    @(negedge clk);
  endtask

  initial begin
    logic [95:0] rnd;
    logic        r_iv, r_c, r_fl, r_or;

    model_clear();
    @(negedge clk);
    #1;
    check_eq("rst.out_valid", 128'(ov0), 128'(1'b0));
    check_eq("rst.stall_cnt", 128'(sc0), 128'(16'd0));
    @(negedge clk);
    rst = 1'b0;

    // Streaming 1..8 at full throughput
    for (int i = 1; i <= 8; i++) cycle("stream", 1'b1, DW'(i), i[0], 1'b0, 1'b1);
    cycle("stream_tail", 1'b0, '0, 1'b0, 1'b0, 1'b1);
    cycle("stream_tail", 1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Backpressure: A, B, C with out_ready low, then drain
    cycle("bp_a", 1'b1, 72'hA, 1'b1, 1'b0, 1'b0);
    cycle("bp_b", 1'b1, 72'hB, 1'b0, 1'b0, 1'b0);
    cycle("bp_c", 1'b1, 72'hC, 1'b1, 1'b0, 1'b0);
    cycle("bp_c", 1'b1, 72'hC, 1'b1, 1'b0, 1'b0);
    cycle("bp_drain", 1'b1, 72'hC, 1'b1, 1'b0, 1'b1);
    cycle("bp_drain", 1'b1, 72'hC, 1'b1, 1'b0, 1'b1);
    cycle("bp_drain", 1'b0, '0, 1'b0, 1'b0, 1'b1);
    cycle("bp_drain", 1'b0, '0, 1'b0, 1'b0, 1'b1);
    check_eq("bp_stall_cnt", 128'(sc0), 128'(16'd3));

    // Flush in SKID with an offered ctrl=1 input, then flush while FULL with in+out transfer
    cycle("fl_d", 1'b1, 72'hD, 1'b1, 1'b0, 1'b0);
    cycle("fl_e", 1'b1, 72'hE, 1'b1, 1'b0, 1'b0);
    cycle("fl_skid", 1'b1, 72'hF, 1'b1, 1'b1, 1'b0);
    cycle("fl_after", 1'b0, '0, 1'b0, 1'b0, 1'b1);
    cycle("fl_g", 1'b1, 72'h6, 1'b1, 1'b0, 1'b1);
    cycle("fl_full", 1'b1, 72'h7, 1'b1, 1'b1, 1'b1);
    cycle("fl_after", 1'b0, '0, 1'b0, 1'b0, 1'b1);
    check_eq("fl_gone", 128'(ov0), 128'(1'b0));

    // Counter saturation on the 4-bit instance
    cycle("sat_load", 1'b1, 72'h5A, 1'b1, 1'b0, 1'b0);
    repeat (20) cycle("sat", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    check_eq("sat_stop", 128'(sc1), 128'(4'd15));
    cycle("sat_drain", 1'b0, '0, 1'b0, 1'b0, 1'b1);
    cycle("sat_drain", 1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Random traffic with occasional flush
    repeat (300) begin
      rnd  = {$urandom, $urandom, $urandom};
      r_iv = 1'($urandom_range(0, 1));
      r_c  = 1'($urandom_range(0, 1));
      r_fl = ($urandom_range(0, 15) == 0);
      r_or = ($urandom_range(0, 3) != 0);
      cycle("rand", r_iv, rnd[DW-1:0], r_c, r_fl, r_or);
    end

    // Asynchronous reset in the middle of SKID state
    cycle("rs_a", 1'b1, 72'h11, 1'b1, 1'b0, 1'b0);
    cycle("rs_b", 1'b1, 72'h22, 1'b1, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_mid.out_valid0", 128'(ov0), 128'(1'b0));
    check_eq("rst_mid.out_ctrl0", 128'(oc0), 128'(1'b0));
    check_eq("rst_mid.stall_cnt0", 128'(sc0), 128'(16'd0));
    check_eq("rst_mid.out_valid1", 128'(ov1), 128'(1'b0));
    check_eq("rst_mid.stall_cnt1", 128'(sc1), 128'(4'd0));
    check_eq("rst_mid.out_valid2", 128'(ov2), 128'(1'b0));
    check_eq("rst_mid.out_ctrl2", 128'(oc2), 128'(1'b0));
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    cycle("rst_after", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    cycle("rst_after", 1'b1, 72'h33, 1'b1, 1'b0, 1'b1);
    cycle("rst_after", 1'b0, '0, 1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
